fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage feeding the control FSM. Holds the PC and instruction register (IR).
//  On do_fetch it reads one instruction word from instruction memory over a req/ack handshake.
//  It decodes the IR into opcode, isaluop and operand fields, and updates the PC on do_next.
// PARAMETERS
//  NIB_WIDTH    4        nibble width, from parameters.v (not overridable here)
//  ADDR_WIDTH   16       PC / instruction address width, word-addressed
//  INSTR_WIDTH  16       instruction word width; must equal 4*NIB_WIDTH
//  RESET_PC     16'h0000 PC value after reset
// PORTS
//  clk          in   1            clock, all state on posedge
//  reset        in   1            asynchronous, active-high reset
//  do_fetch     in   1            from control: fetch instruction at PC (STATE_FETCH)
//  do_next      in   1            from control: advance PC (STATE_NEXT)
//  pc_load      in   1            sampled with do_next: take pc_target instead of PC+1
//  pc_target    in   ADDR_WIDTH   jump/branch destination
//  instr_req    out  1            memory read request, held until instr_ack
//  instr_addr   out  ADDR_WIDTH   read address (= PC)
//  instr_ack    in   1            memory: instr_data valid this cycle
//  instr_data   in   INSTR_WIDTH  instruction word
//  opcode       out  NIB_WIDTH    IR[15:12]
//  isaluop      out  1            ~IR[15]; opcodes with MSB 1 are OP_LOAD..OP_BR class
//  field_a      out  NIB_WIDTH    IR[11:8] (destination register)
//  field_b      out  NIB_WIDTH    IR[7:4]
//  field_c      out  NIB_WIDTH    IR[3:0]
//  imm8         out  2*NIB_WIDTH  IR[7:0]
//  pc_out       out  ADDR_WIDTH   current PC
//  busy         out  1            fetch outstanding; the sequencer must not advance past FETCH
//  seq_error    out  1            sticky: do_fetch/do_next arrived while busy
// BEHAVIOUR
//  Reset (async): PC=RESET_PC, IR=0 (opcode=0, isaluop=1, fields 0), FSM=IDLE, seq_error=0,
//    instr_req=0, busy=0. A reset during WAIT drops the request immediately. A late ack is ignored.
//  FSM states: IDLE, WAIT.
//  IDLE:
//    - instr_req = do_fetch, combinational, with instr_addr=PC.
//    - do_fetch & instr_ack: IR<=instr_data at that edge; stay IDLE (zero-wait memory).
//    - do_fetch & !instr_ack: go to WAIT.
//  WAIT:
//    - instr_req=1, busy=1, instr_addr held at PC.
//    - instr_ack: IR<=instr_data, go to IDLE. busy deasserts the next cycle.
//  do_next in IDLE: PC <= pc_load ? pc_target : PC+1, modulo 2^ADDR_WIDTH (0xFFFF -> 0x0000).
//  do_fetch & do_next in the same cycle (illegal): PC update wins; no fetch; seq_error<=1.
//  do_fetch or do_next while busy: ignored (no PC/IR change); seq_error<=1 (cleared only by reset).
//  Decoded outputs come straight from the IR. They change only on the IR-load edge and are stable
//    through REGLOAD..NEXT.
// CONFIGURATION
//  FETCH_PREFETCH_EN defined:
//    - Adds a 1-entry prefetch buffer (PB) and state PREF.
//    - On the do_next edge, the FSM enters PREF and requests the new PC.
//    - An ack in PREF fills PB; the FSM returns to IDLE.
//    - A later do_fetch with PB valid loads IR from PB at that edge: no request, busy=0.
//    - do_fetch in PREF: go to WAIT. The ack then loads IR directly.
//    - busy is 0 in PREF.
//    - PB is invalidated on reset and after each use.
//  FETCH_PREFETCH_EN undefined: no PB, no PREF state; behaviour exactly as above.
// TESTING
//  1 reset mid-WAIT -> instr_req=0, busy=0 same cycle; PC=RESET_PC, opcode=0; later ack changes nothing
//  2 PC=0, do_fetch, ack same cycle, data=16'h8A5C -> next cycle opcode=8, isaluop=0, field_a=A, imm8=5C, busy never 1
//  3 do_fetch, ack after 3 cycles, data=16'h1234 -> busy=1 for 3 cycles, instr_addr held, then opcode=1, isaluop=1
//  4 PC=16'hFFFF, do_next, pc_load=0 -> PC=0; PC=5, do_next, pc_load=1, pc_target=16'h0100 -> PC=16'h0100
//  5 do_next while busy -> PC unchanged, seq_error=1 and stays 1 until reset
//  6 (FETCH_PREFETCH_EN) do_next to PC=7, ack 2 cycles later, then do_fetch -> IR loads PB that edge, no instr_req

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Holds PC and IR, fetches one word per
// do_fetch over a req/ack handshake, decodes IR fields, advances PC on do_next.
// Optional feature: define FETCH_PREFETCH_EN to add a 1-entry prefetch buffer
// that is filled in the background right after each PC update.
// INSTR_WIDTH is expected to equal 4*NIB_WIDTH (four nibble fields).
module fetch_unit #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    INSTR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   do_fetch,
    input  logic                   do_next,
    input  logic                   pc_load,
    input  logic [ADDR_WIDTH-1:0]  pc_target,
    output logic                   instr_req,
    output logic [ADDR_WIDTH-1:0]  instr_addr,
    input  logic                   instr_ack,
    input  logic [INSTR_WIDTH-1:0] instr_data,
    output logic [3:0]             opcode,
    output logic                   isaluop,
    output logic [3:0]             field_a,
    output logic [3:0]             field_b,
    output logic [3:0]             field_c,
    output logic [7:0]             imm8,
    output logic [ADDR_WIDTH-1:0]  pc_out,
    output logic                   busy,
    output logic                   seq_error
);

    localparam int NIB_WIDTH = 4;

`ifdef FETCH_PREFETCH_EN
    typedef enum logic [1:0] {IDLE, WAIT, PREF} state_t;
`else
    typedef enum logic [1:0] {IDLE, WAIT} state_t;
`endif

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   pc, pc_nxt, pc_step;
    logic [INSTR_WIDTH-1:0]  ir, ir_src;
    logic                    ir_ld;
    logic                    err_set;
    logic                    req_c;

`ifdef FETCH_PREFETCH_EN
    logic [INSTR_WIDTH-1:0]  pb;
    logic                    pb_valid;
    logic                    pb_ld;
    logic                    pb_clr;
`endif

    // PC successor; wraps naturally at 2^ADDR_WIDTH
    assign pc_step = pc_load ? pc_target : pc + ADDR_WIDTH'(1);

    // next-state, PC update, IR load select and handshake outputs
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_ld     = 1'b0;
        ir_src    = instr_data;
        err_set   = 1'b0;
        req_c     = 1'b0;
        busy      = 1'b0;
`ifdef FETCH_PREFETCH_EN
        pb_ld     = 1'b0;
        pb_clr    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (do_next) begin
                    // PC update wins over a simultaneous fetch, which is flagged
                    pc_nxt  = pc_step;
                    err_set = do_fetch;
`ifdef FETCH_PREFETCH_EN
                    pb_clr    = 1'b1;
                    state_nxt = PREF;
`endif
                end else if (do_fetch) begin
`ifdef FETCH_PREFETCH_EN
                    if (pb_valid) begin
                        ir_ld  = 1'b1;
                        ir_src = pb;
                        pb_clr = 1'b1;
                    end else
`endif
                    begin
                        req_c = 1'b1;
                        if (instr_ack) ir_ld     = 1'b1;
                        else           state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                req_c   = 1'b1;
                busy    = 1'b1;
                err_set = do_fetch | do_next;
                if (instr_ack) begin
                    ir_ld     = 1'b1;
                    state_nxt = IDLE;
                end
            end
`ifdef FETCH_PREFETCH_EN
            PREF: begin
                req_c = 1'b1;
                if (do_next) begin
                    // retarget the prefetch; an ack this cycle answers the old PC
                    pc_nxt  = pc_step;
                    err_set = do_fetch;
                end else if (do_fetch) begin
                    if (instr_ack) begin
                        ir_ld     = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end else if (instr_ack) begin
                    pb_ld     = 1'b1;
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // request drops the moment reset asserts, even mid-transaction
    assign instr_req  = req_c & ~reset;
    assign instr_addr = pc;
    assign pc_out     = pc;

    // field decode straight from IR
    assign opcode  = ir[INSTR_WIDTH-1 -: NIB_WIDTH];
    assign isaluop = ~ir[INSTR_WIDTH-1];
    assign field_a = ir[3*NIB_WIDTH-1 -: NIB_WIDTH];
    assign field_b = ir[2*NIB_WIDTH-1 -: NIB_WIDTH];
    assign field_c = ir[NIB_WIDTH-1:0];
    assign imm8    = ir[2*NIB_WIDTH-1:0];

    // state, PC, IR and sticky error registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            ir        <= '0;
            seq_error <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (ir_ld)   ir        <= ir_src;
            if (err_set) seq_error <= 1'b1;
        end
    end

`ifdef FETCH_PREFETCH_EN
    // prefetch buffer: filled by a PREF ack, consumed by the next do_fetch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pb       <= '0;
            pb_valid <= 1'b0;
        end else begin
            if (pb_ld) begin
                pb       <= instr_data;
                pb_valid <= 1'b1;
            end else if (pb_clr) begin
                pb_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// Inputs change on the falling edge; registered results are sampled 1ns after
// the rising edge, combinational handshake outputs 1ns after the falling edge.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        do_fetch, do_next, pc_load, instr_ack;
    logic [15:0] pc_target, instr_data;
    logic        instr_req, isaluop, busy, seq_error;
    logic [15:0] instr_addr, pc_out;
    logic [3:0]  opcode, field_a, field_b, field_c;
    logic [7:0]  imm8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .reset(reset), .do_fetch(do_fetch), .do_next(do_next),
        .pc_load(pc_load), .pc_target(pc_target), .instr_req(instr_req),
        .instr_addr(instr_addr), .instr_ack(instr_ack), .instr_data(instr_data),
        .opcode(opcode), .isaluop(isaluop), .field_a(field_a), .field_b(field_b),
        .field_c(field_c), .imm8(imm8), .pc_out(pc_out), .busy(busy),
        .seq_error(seq_error)
    );

    // drive one PC load to an arbitrary target through do_next/pc_load
    task automatic load_pc(input logic [15:0] tgt);
        @(negedge clk);
        do_next = 1'b1; pc_load = 1'b1; pc_target = tgt;
        @(posedge clk); #1;
        @(negedge clk);
        do_next = 1'b0; pc_load = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        do_fetch = 1'b0; do_next = 1'b0; pc_load = 1'b0; instr_ack = 1'b0;
        pc_target = 16'h0; instr_data = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({pc_out, opcode, isaluop, field_a, field_b, field_c, imm8} !== {16'h0, 4'h0, 1'b1, 12'h0, 8'h0}) begin
            errors++;
            $display("FAIL reset_decode: pc=%h op=%h alu=%b a=%h b=%h c=%h imm=%h want pc=0 op=0 alu=1 fields=0",
                     pc_out, opcode, isaluop, field_a, field_b, field_c, imm8);
        end
        checks++;
        if ({instr_req, busy, seq_error} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: req/busy/err=%b%b%b want 000", instr_req, busy, seq_error);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_zero_wait;
        @(negedge clk);
        do_fetch = 1'b1; instr_ack = 1'b1; instr_data = 16'h8A5C;
        #1;
        checks++;
        if ({instr_req, instr_addr, busy} !== {1'b1, 16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL zw_req: req=%b addr=%h busy=%b want 1 0000 0", instr_req, instr_addr, busy);
        end
        @(posedge clk); #1;
        checks++;
        if ({opcode, isaluop, field_a, field_b, field_c, imm8} !== {4'h8, 1'b0, 4'hA, 4'h5, 4'hC, 8'h5C}) begin
            errors++;
            $display("FAIL zw_decode: op=%h alu=%b a=%h b=%h c=%h imm=%h want 8 0 A 5 C 5C",
                     opcode, isaluop, field_a, field_b, field_c, imm8);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL zw_busy: busy=%b want 0", busy);
        end
        @(negedge clk);
        do_fetch = 1'b0; instr_ack = 1'b0;
    endtask

    task automatic test_wait_fetch;
        // advance PC to 1, then fetch with a 3-cycle memory
        @(negedge clk);
        do_next = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (pc_out !== 16'h0001) begin
            errors++;
            $display("FAIL wf_pc_inc: pc=%h want 0001", pc_out);
        end
        @(negedge clk);
        do_next = 1'b0; do_fetch = 1'b1;
        @(posedge clk);
        @(negedge clk);
        do_fetch = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if ({busy, instr_req, instr_addr, opcode} !== {1'b1, 1'b1, 16'h0001, 4'h8}) begin
                errors++;
                $display("FAIL wf_wait%0d: busy=%b req=%b addr=%h op=%h want 1 1 0001 8",
                         i, busy, instr_req, instr_addr, opcode);
            end
            if (i == 2) begin
                instr_ack = 1'b1; instr_data = 16'h1234;
            end
            @(posedge clk);
        end
        #1;
        checks++;
        if ({opcode, isaluop, field_a, imm8, busy, instr_req} !== {4'h1, 1'b1, 4'h2, 8'h34, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL wf_done: op=%h alu=%b a=%h imm=%h busy=%b req=%b want 1 1 2 34 0 0",
                     opcode, isaluop, field_a, imm8, busy, instr_req);
        end
        @(negedge clk);
        instr_ack = 1'b0;
    endtask

    task automatic test_pc_update;
        load_pc(16'hFFFF);
        checks++;
        if (pc_out !== 16'hFFFF) begin
            errors++;
            $display("FAIL pc_load_ffff: pc=%h want FFFF", pc_out);
        end
        @(negedge clk);
        do_next = 1'b1; pc_load = 1'b0; pc_target = 16'h1234;
        @(posedge clk); #1;
        checks++;
        if (pc_out !== 16'h0000) begin
            errors++;
            $display("FAIL pc_wrap: pc=%h want 0000", pc_out);
        end
        @(negedge clk);
        do_next = 1'b0;
        load_pc(16'h0005);
        @(negedge clk);
        do_next = 1'b1; pc_load = 1'b1; pc_target = 16'h0100;
        @(posedge clk); #1;
        checks++;
        if ({pc_out, seq_error} !== {16'h0100, 1'b0}) begin
            errors++;
            $display("FAIL pc_jump: pc=%h err=%b want 0100 0", pc_out, seq_error);
        end
        @(negedge clk);
        do_next = 1'b0; pc_load = 1'b0;
    endtask

    task automatic test_seq_error;
        // enter WAIT at PC=0100, then poke do_next while busy
        @(negedge clk);
        do_fetch = 1'b1;
        @(posedge clk);
        @(negedge clk);
        do_fetch = 1'b0; do_next = 1'b1; pc_load = 1'b1; pc_target = 16'h0BAD;
        @(posedge clk); #1;
        checks++;
        if ({pc_out, seq_error, busy} !== {16'h0100, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL se_busy_next: pc=%h err=%b busy=%b want 0100 1 1", pc_out, seq_error, busy);
        end
        @(negedge clk);
        do_next = 1'b0; pc_load = 1'b0; instr_ack = 1'b1; instr_data = 16'h7123;
        @(posedge clk); #1;
        checks++;
        if ({opcode, isaluop, busy, seq_error} !== {4'h7, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL se_ack: op=%h alu=%b busy=%b err=%b want 7 1 0 1", opcode, isaluop, busy, seq_error);
        end
        @(negedge clk);
        instr_ack = 1'b0;
        // illegal do_fetch+do_next: PC advances, no fetch
        @(negedge clk);
        do_fetch = 1'b1; do_next = 1'b1; instr_data = 16'hF000;
        #1;
        checks++;
        if (instr_req !== 1'b0) begin
            errors++;
            $display("FAIL se_both_req: req=%b want 0", instr_req);
        end
        @(posedge clk); #1;
        checks++;
        if ({pc_out, opcode, busy, seq_error} !== {16'h0101, 4'h7, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL se_both: pc=%h op=%h busy=%b err=%b want 0101 7 0 1", pc_out, opcode, busy, seq_error);
        end
        @(negedge clk);
        do_fetch = 1'b0; do_next = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (seq_error !== 1'b1) begin
            errors++;
            $display("FAIL se_sticky: err=%b want 1", seq_error);
        end
    endtask

    task automatic test_reset_mid_wait;
        @(negedge clk);
        do_fetch = 1'b1;
        @(posedge clk);
        @(negedge clk);
        do_fetch = 1'b0;
        #1;
        checks++;
        if ({busy, instr_req} !== 2'b11) begin
            errors++;
            $display("FAIL rw_pre: busy=%b req=%b want 1 1", busy, instr_req);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({instr_req, busy, pc_out, opcode, seq_error} !== {1'b0, 1'b0, 16'h0000, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL rw_reset: req=%b busy=%b pc=%h op=%h err=%b want 0 0 0000 0 0",
                     instr_req, busy, pc_out, opcode, seq_error);
        end
        @(negedge clk);
        reset = 1'b0; instr_ack = 1'b1; instr_data = 16'hFEDC;
        @(posedge clk); #1;
        checks++;
        if ({opcode, isaluop, pc_out, busy, instr_req} !== {4'h0, 1'b1, 16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rw_late_ack: op=%h alu=%b pc=%h busy=%b req=%b want 0 1 0000 0 0",
                     opcode, isaluop, pc_out, busy, instr_req);
        end
        @(negedge clk);
        instr_ack = 1'b0;
    endtask

`ifdef FETCH_PREFETCH_EN
    task automatic test_prefetch;
        load_pc(16'h0006);
        // load_pc itself starts a prefetch at 6; let it complete
        @(negedge clk);
        instr_ack = 1'b1; instr_data = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        instr_ack = 1'b0; do_next = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({pc_out, busy} !== {16'h0007, 1'b0}) begin
            errors++;
            $display("FAIL pf_next: pc=%h busy=%b want 0007 0", pc_out, busy);
        end
        @(negedge clk);
        do_next = 1'b0;
        #1;
        checks++;
        if ({instr_req, instr_addr, busy} !== {1'b1, 16'h0007, 1'b0}) begin
            errors++;
            $display("FAIL pf_req: req=%b addr=%h busy=%b want 1 0007 0", instr_req, instr_addr, busy);
        end
        @(negedge clk);
        instr_ack = 1'b1; instr_data = 16'h9ABC;
        @(posedge clk);
        @(negedge clk);
        instr_ack = 1'b0; instr_data = 16'h0000; do_fetch = 1'b1;
        #1;
        checks++;
        if ({instr_req, busy} !== 2'b00) begin
            errors++;
            $display("FAIL pf_use_req: req=%b busy=%b want 0 0", instr_req, busy);
        end
        @(posedge clk); #1;
        checks++;
        if ({opcode, isaluop, imm8} !== {4'h9, 1'b0, 8'hBC}) begin
            errors++;
            $display("FAIL pf_use: op=%h alu=%b imm=%h want 9 0 BC", opcode, isaluop, imm8);
        end
        @(negedge clk);
        do_fetch = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_zero_wait;
        test_wait_fetch;
        test_pc_update;
        test_seq_error;
        test_reset_mid_wait;
`ifdef FETCH_PREFETCH_EN
        test_prefetch;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
